// File: rtl/z80_comm_latch.sv
// -----------------------------------------------------------------------------
// z80_comm_latch
//
// Bidirectional 68K <-> Z80 sound communication latch in the CLK_24M domain.
// A command byte travels 68K -> Z80 and a reply byte travels Z80 -> 68K; each
// has its own pending flag.  Every bus strobe is asynchronous and is brought
// into CLK_24M through a synchronizer.  An action takes effect when its strobe
// is released (the rising edge, "commit").  A command commit also raises a
// fixed-length NMI request to the Z80.
//
// Optional feature (compile-time macro STROBE_FILTER_EN):
//   defined   - adds a third sync stage.  The strobe state changes only after
//               two consistent samples, so single-cycle glitches are rejected.
//               Commit lands 3 edges after the strobe rises, and strobes must
//               be low for at least 3 cycles.
//   undefined - two-stage synchronizer.  Commit lands 2 edges after the
//               strobe rises.
//
// Parameters:
//   NMI_WIDTH     nZ80NMI low pulse length in CLK_24M cycles (legal 1..255)
//
// Ports:
//   CLK_24M       in   system clock, 24 MHz
//   nRESET        in   synchronous active-low reset
//   M68K_DATA     in   [7:0] 68K data bus, low byte
//   nSOUNDW       in   68K command-write strobe (active low, async)
//   nSOUNDR       in   68K reply-read strobe (active low, async)
//   SDD_IN        in   [7:0] Z80 data bus
//   nSDZ80R       in   Z80 command-read strobe (active low, async)
//   nSDZ80W       in   Z80 reply-write strobe (active low, async)
//   nSDZ80CLR     in   Z80 command-clear strobe (active low, async)
//   NMI_MASK      in   1 = do not start an NMI on command commit
//   CMD_DATA      out  [7:0] latched command byte
//   REPLY_DATA    out  [7:0] latched reply byte
//   CMD_PENDING   out  command written, not yet read/cleared by the Z80
//   REPLY_PENDING out  reply written, not yet read by the 68K
//   CMD_OVERRUN   out  sticky: command overwritten while still pending
//   nZ80NMI       out  Z80 NMI request, active low
// -----------------------------------------------------------------------------
module z80_comm_latch #(
  parameter int unsigned NMI_WIDTH = 24
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  input  logic [7:0] M68K_DATA,
  input  logic       nSOUNDW,
  input  logic       nSOUNDR,
  input  logic [7:0] SDD_IN,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic       nSDZ80CLR,
  input  logic       NMI_MASK,
  output logic [7:0] CMD_DATA,
  output logic [7:0] REPLY_DATA,
  output logic       CMD_PENDING,
  output logic       REPLY_PENDING,
  output logic       CMD_OVERRUN,
  output logic       nZ80NMI
);

  // Bit positions of the strobes inside the synchronizer vectors
  localparam int IDX_SOUNDW = 0;
  localparam int IDX_SOUNDR = 1;
  localparam int IDX_Z80R   = 2;
  localparam int IDX_Z80W   = 3;
  localparam int IDX_Z80CLR = 4;

  localparam logic [7:0] NMI_LOAD = 8'(NMI_WIDTH);

  logic [4:0] w_strb_raw;
  logic [4:0] r_s1;
  logic [4:0] r_s2;
  logic [4:0] r_h;
  logic [4:0] w_h_next;
  logic [4:0] w_commit;
`ifdef STROBE_FILTER_EN
  logic [4:0] r_s3;
  logic [4:0] w_stable;
`endif

  logic       w_snap_68k_en;
  logic       w_snap_z80_en;
  logic [7:0] r_d1_68k;
  logic [7:0] r_d1_z80;
  logic [7:0] r_snap_68k;
  logic [7:0] r_snap_z80;

  logic       w_cmd_wr;
  logic       w_cmd_rd;
  logic       w_cmd_clr;
  logic       w_rep_wr;
  logic       w_rep_rd;

  logic [7:0] r_nmi_cnt;

  assign w_strb_raw = {nSDZ80CLR, nSDZ80W, nSDZ80R, nSOUNDR, nSOUNDW};

  // Two-stage synchronizer for all five strobes
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_s1 <= 5'b11111;
      r_s2 <= 5'b11111;
    end else begin
      r_s1 <= w_strb_raw;
      r_s2 <= r_s1;
    end
  end

`ifdef STROBE_FILTER_EN
  // Third sync stage used for the two-sample consistency check
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_s3 <= 5'b11111;
    end else begin
      r_s3 <= r_s2;
    end
  end
`endif

  // Strobe history update, commit detection and snapshot enables
  always_comb begin
`ifdef STROBE_FILTER_EN
    // History only follows S2 once S2 and S3 agree; a lone low sample in
    // S2 never coincides with a low S3, so it cannot move the history.
    w_stable      = ~(r_s2 ^ r_s3);
    w_h_next      = (w_stable & r_s2) | (~w_stable & r_h);
    w_commit      = r_s2 & r_s3 & ~r_h;
    w_snap_68k_en = ~r_s1[IDX_SOUNDW] & ~r_s2[IDX_SOUNDW];
    w_snap_z80_en = ~r_s1[IDX_Z80W]   & ~r_s2[IDX_Z80W];
`else
    w_h_next      = r_s2;
    w_commit      = r_s2 & ~r_h;
    w_snap_68k_en = ~r_s1[IDX_SOUNDW];
    w_snap_z80_en = ~r_s1[IDX_Z80W];
`endif
  end

  // Strobe history flops: commit fires on the 0 -> 1 transition of the strobe state
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_h <= 5'b11111;
    end else begin
      r_h <= w_h_next;
    end
  end

  assign w_cmd_wr  = w_commit[IDX_SOUNDW];
  assign w_rep_rd  = w_commit[IDX_SOUNDR];
  assign w_cmd_rd  = w_commit[IDX_Z80R];
  assign w_rep_wr  = w_commit[IDX_Z80W];
  assign w_cmd_clr = w_commit[IDX_Z80CLR];

  // Data bus registers (aligned with S1) and write snapshots.
  // The snapshot keeps reloading while the write strobe is seen low, so it
  // holds the last byte present before the strobe was released.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_d1_68k   <= 8'h00;
      r_d1_z80   <= 8'h00;
      r_snap_68k <= 8'h00;
      r_snap_z80 <= 8'h00;
    end else begin
      r_d1_68k <= M68K_DATA;
      r_d1_z80 <= SDD_IN;
      if (w_snap_68k_en) begin
        r_snap_68k <= r_d1_68k;
      end
      if (w_snap_z80_en) begin
        r_snap_z80 <= r_d1_z80;
      end
    end
  end

  // Command latch, pending and overrun flags (a 68K write beats a Z80 read/clear)
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      CMD_DATA    <= 8'h00;
      CMD_PENDING <= 1'b0;
      CMD_OVERRUN <= 1'b0;
    end else begin
      if (w_cmd_wr) begin
        CMD_DATA    <= r_snap_68k;
        CMD_PENDING <= 1'b1;
      end else if (w_cmd_rd || w_cmd_clr) begin
        CMD_PENDING <= 1'b0;
      end

      // Clear has priority; a write that coincides with a read or clear is
      // the Z80 consuming the old byte, so it is not an overrun.
      if (w_cmd_clr) begin
        CMD_OVERRUN <= 1'b0;
      end else if (w_cmd_wr && CMD_PENDING && !w_cmd_rd) begin
        CMD_OVERRUN <= 1'b1;
      end
    end
  end

  // Reply latch and pending flag (a Z80 write beats a 68K read)
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      REPLY_DATA    <= 8'h00;
      REPLY_PENDING <= 1'b0;
    end else begin
      if (w_rep_wr) begin
        REPLY_DATA    <= r_snap_z80;
        REPLY_PENDING <= 1'b1;
      end else if (w_rep_rd) begin
        REPLY_PENDING <= 1'b0;
      end
    end
  end

  // NMI pulse generator.  The output goes high on the edge that consumes the
  // last count, which yields exactly NMI_WIDTH low cycles; a new command
  // reloads the counter and stretches the pulse.  The mask only gates the
  // start of a pulse, never an ongoing one.
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      r_nmi_cnt <= 8'h00;
      nZ80NMI   <= 1'b1;
    end else if (w_cmd_wr && !NMI_MASK) begin
      r_nmi_cnt <= NMI_LOAD;
      nZ80NMI   <= 1'b0;
    end else if (r_nmi_cnt != 8'h00) begin
      r_nmi_cnt <= r_nmi_cnt - 8'h01;
      nZ80NMI   <= (r_nmi_cnt == 8'h01);
    end else begin
      nZ80NMI   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_z80_comm_latch.sv
// -----------------------------------------------------------------------------
// tb_z80_comm_latch
//
// Self-checking bench for z80_comm_latch.  A small reference model tracks the
// latch contents; each strobe transaction pushes the expected output state to
// a scoreboard queue, which is popped and compared once the commit latency
// has elapsed.  NMI pulse lengths are measured by a free-running monitor.
// -----------------------------------------------------------------------------
module tb_z80_comm_latch;

`ifdef STROBE_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] rep;
    logic       cp;
    logic       rp;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] m68k_data;
  logic       n_soundw;
  logic       n_soundr;
  logic [7:0] sdd_in;
  logic       n_z80r;
  logic       n_z80w;
  logic       n_z80clr;
  logic       nmi_mask;
  logic [7:0] cmd_data;
  logic [7:0] reply_data;
  logic       cmd_pending;
  logic       reply_pending;
  logic       cmd_overrun;
  logic       n_nmi;

  exp_t       sb_q[$];
  logic [7:0] m_cmd;
  logic [7:0] m_rep;
  logic       m_cp;
  logic       m_rp;
  logic       m_ov;

  int n_checks = 0;
  int n_fail   = 0;
  int nmi_run    = 0;
  int nmi_last   = 0;
  int nmi_pulses = 0;
  int p0;

  always #20 clk = ~clk;

  z80_comm_latch #(.NMI_WIDTH(24)) dut (
    .CLK_24M      (clk),
    .nRESET       (n_reset),
    .M68K_DATA    (m68k_data),
    .nSOUNDW      (n_soundw),
    .nSOUNDR      (n_soundr),
    .SDD_IN       (sdd_in),
    .nSDZ80R      (n_z80r),
    .nSDZ80W      (n_z80w),
    .nSDZ80CLR    (n_z80clr),
    .NMI_MASK     (nmi_mask),
    .CMD_DATA     (cmd_data),
    .REPLY_DATA   (reply_data),
    .CMD_PENDING  (cmd_pending),
    .REPLY_PENDING(reply_pending),
    .CMD_OVERRUN  (cmd_overrun),
    .nZ80NMI      (n_nmi)
  );

  // NMI monitor: length of each completed low pulse in clock cycles
  always @(negedge clk) begin
    if (n_nmi == 1'b0) begin
      nmi_run <= nmi_run + 1;
    end else if (nmi_run > 0) begin
      nmi_last   <= nmi_run;
      nmi_pulses <= nmi_pulses + 1;
      nmi_run    <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_strobes(input logic [4:0] lvl);
    n_soundw = lvl[0];
    n_soundr = lvl[1];
    n_z80r   = lvl[2];
    n_z80w   = lvl[3];
    n_z80clr = lvl[4];
  endtask

  task automatic model_reset();
    m_cmd = 8'h00;
    m_rep = 8'h00;
    m_cp  = 1'b0;
    m_rp  = 1'b0;
    m_ov  = 1'b0;
  endtask

  // mask bits: 0 soundw, 1 soundr, 2 z80r, 3 z80w, 4 z80clr
  task automatic model_commit(input logic [4:0] m, input logic [7:0] d68, input logic [7:0] dz);
    logic ov_set;
    ov_set = m[0] && m_cp && !m[2] && !m[4];
    if (m[0]) begin
      m_cmd = d68;
      m_cp  = 1'b1;
    end else if (m[2] || m[4]) begin
      m_cp = 1'b0;
    end
    if (m[4]) begin
      m_ov = 1'b0;
    end else if (ov_set) begin
      m_ov = 1'b1;
    end
    if (m[3]) begin
      m_rep = dz;
      m_rp  = 1'b1;
    end else if (m[1]) begin
      m_rp = 1'b0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.cmd = m_cmd;
    e.rep = m_rep;
    e.cp  = m_cp;
    e.rp  = m_rp;
    e.ov  = m_ov;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_cmd"}, 32'(cmd_data),      32'(e.cmd));
      check_val({tag, "_rep"}, 32'(reply_data),    32'(e.rep));
      check_val({tag, "_cp"},  32'(cmd_pending),   32'(e.cp));
      check_val({tag, "_rp"},  32'(reply_pending), 32'(e.rp));
      check_val({tag, "_ov"},  32'(cmd_overrun),   32'(e.ov));
    end
  endtask

  // Drive a strobe transaction: strobes in 'mask' low for 'len' cycles, then
  // released; data buses are scrambled right after release to prove the
  // snapshot holds the byte present while the strobe was low.
  task automatic xfer(input string tag, input logic [4:0] mask, input int len,
                      input logic [7:0] d68, input logic [7:0] dz);
    logic old_cp;
    logic old_rp;
    old_cp    = m_cp;
    old_rp    = m_rp;
    m68k_data = d68;
    sdd_in    = dz;
    set_strobes(~mask);
    tick(len);
    set_strobes(5'b11111);
    m68k_data = ~d68;
    sdd_in    = ~dz;
    model_commit(mask, d68, dz);
    push_exp();
    tick(LAT);
    check_val({tag, "_early_cp"}, 32'(cmd_pending),   32'(old_cp));
    check_val({tag, "_early_rp"}, 32'(reply_pending), 32'(old_rp));
    tick(1);
    compare_out(tag);
  endtask

  task automatic wait_pulse(input string tag, input int start_cnt, input int exp_len);
    int guard;
    guard = 0;
    while (nmi_pulses == start_cnt && guard < 300) begin
      tick(1);
      guard++;
    end
    check_val({tag, "_done"}, 32'(nmi_pulses != start_cnt), 32'd1);
    if (nmi_pulses != start_cnt) begin
      check_val({tag, "_len"}, 32'(nmi_last), 32'(exp_len));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset   = 1'b1;
    nmi_mask  = 1'b0;
    m68k_data = 8'h00;
    sdd_in    = 8'h00;
    set_strobes(5'b11111);
    model_reset();

    // Reset with all strobes low and junk on the data buses
    n_reset   = 1'b0;
    set_strobes(5'b00000);
    m68k_data = 8'hFF;
    sdd_in    = 8'hFF;
    tick(3);
    push_exp();
    compare_out("reset");
    check_val("reset_nmi", 32'(n_nmi), 32'd1);
    set_strobes(5'b11111);
    n_reset = 1'b1;
    tick(6);
    push_exp();
    compare_out("post_reset");
    check_val("post_reset_nmi", 32'(n_nmi), 32'd1);
    check_val("post_reset_pulses", 32'(nmi_pulses), 32'd0);

    // Command write with NMI
    nmi_mask = 1'b0;
    p0 = nmi_pulses;
    xfer("cmd_a5", 5'b00001, 4, 8'hA5, 8'h00);
    check_val("cmd_a5_nmi_low", 32'(n_nmi), 32'd0);
    wait_pulse("cmd_a5_nmi", p0, 24);
    xfer("z80_read", 5'b00100, 4, 8'hEE, 8'h00);

    // Overrun and clear, with NMI masked (minimum-width strobe on the second write)
    nmi_mask = 1'b1;
    p0 = nmi_pulses;
    xfer("ovr_w1", 5'b00001, 4, 8'h11, 8'h00);
    xfer("ovr_w2", 5'b00001, LAT, 8'h22, 8'h00);
    xfer("ovr_clr", 5'b10000, 4, 8'h99, 8'h00);

    // Simultaneous commits
    xfer("pend_44", 5'b00001, 4, 8'h44, 8'h00);
    xfer("sim_wr_rd", 5'b00101, 4, 8'h33, 8'h00);
    check_val("sim_wr_rd_nmi", 32'(n_nmi), 32'd1);
    xfer("ovr_again", 5'b00001, 4, 8'h55, 8'h00);
    xfer("sim_wr_clr", 5'b10001, 4, 8'h56, 8'h00);
    check_val("masked_no_pulses", 32'(nmi_pulses), 32'(p0));

    // Reply path
    xfer("reply_5a", 5'b01000, 4, 8'h00, 8'h5A);
    xfer("reply_read", 5'b00010, 4, 8'h00, 8'h77);
    xfer("reply_c3", 5'b01000, 4, 8'h00, 8'hC3);
    xfer("sim_rep", 5'b01010, 4, 8'h00, 8'h3C);

    // NMI extension: second command commits 10 cycles into the pulse
    nmi_mask = 1'b0;
    p0 = nmi_pulses;
    xfer("ext_w1", 5'b00001, 4, 8'h66, 8'h00);
    xfer("ext_w2", 5'b00001, 9 - LAT, 8'h67, 8'h00);
    check_val("ext_nmi_low", 32'(n_nmi), 32'd0);
    wait_pulse("nmi_ext", p0, 34);

    // Raising the mask mid-pulse does not shorten it
    p0 = nmi_pulses;
    xfer("mask_mid", 5'b00001, 4, 8'h78, 8'h00);
    nmi_mask = 1'b1;
    wait_pulse("nmi_mask_mid", p0, 24);
    nmi_mask = 1'b0;

    // Reset in the middle of a pulse ends it at once
    xfer("rst_mid_w", 5'b00001, 4, 8'h88, 8'h00);
    tick(5);
    n_reset = 1'b0;
    tick(1);
    check_val("rst_mid_nmi", 32'(n_nmi), 32'd1);
    model_reset();
    push_exp();
    compare_out("rst_mid");
    n_reset = 1'b1;
    tick(30);
    check_val("rst_mid_nmi_stays", 32'(n_nmi), 32'd1);

`ifdef STROBE_FILTER_EN
    // Single-cycle glitch is rejected: no commit, no NMI
    p0 = nmi_pulses;
    m68k_data = 8'h99;
    n_soundw  = 1'b0;
    tick(1);
    n_soundw  = 1'b1;
    tick(8);
    push_exp();
    compare_out("glitch");
    check_val("glitch_nmi", 32'(n_nmi), 32'd1);
    check_val("glitch_pulses", 32'(nmi_pulses), 32'(p0));
    // Three-cycle strobe commits
    xfer("filt_3cyc", 5'b00001, 3, 8'hB4, 8'h00);
    wait_pulse("filt_3cyc_nmi", p0, 24);
`endif

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
